// File: rtl/uart_tx_cfg.sv
// Configurable-frame UART transmitter: start, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
// Define UART_TX_CFG_PARITY_EN to build the parity state; otherwise parity_mode is ignored and frames carry no parity.
module uart_tx_cfg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_axi_tdata,
  input  logic                  input_axi_tvalid,
  output logic                  input_axi_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH);
  localparam int unsigned TIMER_W = 19;
  localparam int unsigned PRE_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_CFG_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state, state_n;
  logic [TIMER_W-1:0]    timer, timer_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [PRE_W-1:0]      prescale_q, pre_n;
  logic                  stop2_q, stop2_n;
  logic                  second_stop, second_n;
  logic                  txd_n, busy_n, tready_n;
  logic [PRE_W-1:0]      pre_eff;
  logic [TIMER_W-1:0]    bit_time;
  logic                  timer_done;

`ifdef UART_TX_CFG_PARITY_EN
  logic par_en_q, par_en_n;
  logic par_bit_q, par_bit_n;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  // A prescale of 0 is run as 1 so a bit is never shorter than 8 clocks
  assign pre_eff    = (prescale == PRE_W'(0)) ? PRE_W'(1) : prescale;
  assign bit_time   = {prescale_q, 3'b000} - TIMER_W'(1);
  assign timer_done = (timer == TIMER_W'(0));

  // State and frame registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      timer            <= '0;
      bit_cnt          <= '0;
      data_q           <= '0;
      prescale_q       <= PRE_W'(1);
      stop2_q          <= 1'b0;
      second_stop      <= 1'b0;
      txd              <= 1'b1;
      busy             <= 1'b0;
      input_axi_tready <= 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
      par_en_q         <= 1'b0;
      par_bit_q        <= 1'b0;
`endif
    end else begin
      state            <= state_n;
      timer            <= timer_n;
      bit_cnt          <= bit_cnt_n;
      data_q           <= data_n;
      prescale_q       <= pre_n;
      stop2_q          <= stop2_n;
      second_stop      <= second_n;
      txd              <= txd_n;
      busy             <= busy_n;
      input_axi_tready <= tready_n;
`ifdef UART_TX_CFG_PARITY_EN
      par_en_q         <= par_en_n;
      par_bit_q        <= par_bit_n;
`endif
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    data_n    = data_q;
    pre_n     = prescale_q;
    stop2_n   = stop2_q;
    second_n  = second_stop;
    txd_n     = txd;
    busy_n    = 1'b1;
    tready_n  = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
`endif

    if (state != S_IDLE) begin
      timer_n = timer_done ? bit_time : timer - TIMER_W'(1);
    end

    case (state)
      S_IDLE: begin
        txd_n    = 1'b1;
        busy_n   = 1'b0;
        tready_n = 1'b1;
        if (input_axi_tvalid && input_axi_tready) begin
          state_n   = S_START;
          data_n    = input_axi_tdata;
          pre_n     = pre_eff;
          stop2_n   = stop_bits;
          second_n  = 1'b0;
          bit_cnt_n = '0;
          timer_n   = {pre_eff, 3'b000} - TIMER_W'(1);
          txd_n     = 1'b0;
          busy_n    = 1'b1;
          tready_n  = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
          // Modes 01 (even) and 10 (odd) enable parity; 11 falls back to none
          par_en_n  = parity_mode[0] ^ parity_mode[1];
          par_bit_n = (^input_axi_tdata) ^ parity_mode[1];
`endif
        end
      end
      S_START: begin
        if (timer_done) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
          txd_n     = data_q[0];
        end
      end
      S_DATA: begin
        if (timer_done) begin
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_CFG_PARITY_EN
            if (par_en_q) begin
              state_n = S_PARITY;
              txd_n   = par_bit_q;
            end else
`endif
            begin
              state_n = S_STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
            data_n    = data_q >> 1;
            txd_n     = data_q[1];
          end
        end
      end
`ifdef UART_TX_CFG_PARITY_EN
      S_PARITY: begin
        if (timer_done) begin
          state_n = S_STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        txd_n = 1'b1;
        if (timer_done) begin
          if (stop2_q && !second_stop) begin
            second_n = 1'b1;
          end else begin
            state_n  = S_IDLE;
            busy_n   = 1'b0;
            tready_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: driver pushes expected frames, a negedge monitor pops and compares the line.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic        stop_bits;

  uart_tx_cfg #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input_axi_tdata  (tdata),
    .input_axi_tvalid (tvalid),
    .input_axi_tready (tready),
    .txd              (txd),
    .busy             (busy),
    .prescale         (prescale),
    .parity_mode      (parity_mode),
    .stop_bits        (stop_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lv;
    int          nbits;
    int          p8;
    int          f;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;
  int   last_f = 0;
  int   abort_len = 0;
  bit   aborting = 0;
  bit   mon_en = 0;
  bit   in_frame = 0;
  int   k = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, expv, cyc);
    end
  endtask

  // Reference frame: list of line levels, one per bit time, built from the frame rules
  function automatic exp_t model(input logic [7:0] d, input int pre, input logic [1:0] pm, input logic sb);
    exp_t e;
    int   n;
    int   ones;
    bit   par_on;
    bit   par_bit;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par_bit = (pm == 2'b10) ? (ones % 2 == 0) : (ones % 2 == 1);
    par_on = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
    par_on = (pm == 2'b01) || (pm == 2'b10);
`endif
    e.lv = '1;
    n = 0;
    e.lv[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      e.lv[n] = d[i];
      n++;
    end
    if (par_on) begin
      e.lv[n] = par_bit;
      n++;
    end
    n += sb ? 2 : 1;
    e.nbits = n;
    e.p8    = 8 * ((pre == 0) ? 1 : pre);
    e.f     = n * e.p8;
    e.acc   = 0;
    return e;
  endfunction

  // Offer a byte; returns at the negedge right after the accepting edge
  task automatic send(input logic [7:0] d, input logic [15:0] pre, input logic [1:0] pm,
                      input logic sb, input bit b2b);
    exp_t e;
    int   n;
    tdata = d; prescale = pre; parity_mode = pm; stop_bits = sb; tvalid = 1'b1;
    n = 0;
    while (tready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (tready !== 1'b1) begin
      check(1'b0, "accept_timeout", n, 5000);
      tvalid = 1'b0;
      return;
    end
    e = model(d, int'(pre), pm, sb);
    e.acc = cyc + 1;
    if (b2b) check(e.acc - last_acc == last_f + 1, "b2b_spacing", e.acc - last_acc, last_f + 1);
    exp_q.push_back(e);
    last_acc = e.acc;
    last_f   = e.f;
    @(negedge clk);
    tvalid = 1'b0;
    tdata = 8'($urandom); prescale = 16'($urandom); parity_mode = 2'($urandom); stop_bits = 1'($urandom);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (tready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tready === 1'b1 && cyc == last_acc + last_f, "tready_return", cyc - last_acc, last_f);
  endtask

  // Monitor: compare each busy cycle's line level against the popped frame
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        if (!in_frame) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_frame", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            k = 0;
            bad = 0;
          end
        end
        if (in_frame) begin
          if (k < cur.f && txd !== cur.lv[k / cur.p8]) bad++;
          k++;
        end
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          if (aborting) begin
            check(k == abort_len, "abort_len", k, abort_len);
            aborting = 1'b0;
          end else begin
            check(k == cur.f, "frame_len", k, cur.f);
          end
          check(bad == 0, "frame_bits", bad, 0);
        end
        check(txd === 1'b1, "idle_txd", int'(txd), 1);
      end
    end
  end

  initial begin
    bit b2b_next;
    bit b2b_flag;
    rst_n = 1'b0; tvalid = 1'b0; tdata = 8'h00;
    prescale = 16'd1; parity_mode = 2'b00; stop_bits = 1'b0;
    repeat (3) @(negedge clk);
    check(txd === 1'b1, "rst_txd", int'(txd), 1);
    check(busy === 1'b0, "rst_busy", int'(busy), 0);
    check(tready === 1'b0, "rst_tready", int'(tready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check(tready === 1'b1, "release_tready", int'(tready), 1);
    mon_en = 1'b1;

    // 8N1, even/odd parity, two stop bits, prescale 0, reserved parity mode
    send(8'hA5, 16'd1, 2'b00, 1'b0, 1'b0); wait_ready();
    send(8'hA5, 16'd1, 2'b01, 1'b0, 1'b0); wait_ready();
    send(8'hA5, 16'd1, 2'b10, 1'b0, 1'b0); wait_ready();
    send(8'h00, 16'd2, 2'b00, 1'b1, 1'b0); wait_ready();
    send(8'h96, 16'd0, 2'b00, 1'b1, 1'b0); wait_ready();
    send(8'h3B, 16'd1, 2'b11, 1'b0, 1'b0); wait_ready();

    // Back-to-back with tvalid held
    send(8'h55, 16'd1, 2'b00, 1'b0, 1'b0);
    send(8'h0F, 16'd1, 2'b00, 1'b0, 1'b1);
    wait_ready();

    // Reset during the third data bit
    send(8'h3C, 16'd1, 2'b00, 1'b0, 1'b0);
    while (cyc < last_acc + 26) @(negedge clk);
    abort_len = cyc + 1 - last_acc;
    aborting = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check(txd === 1'b1, "midrst_txd", int'(txd), 1);
    check(busy === 1'b0, "midrst_busy", int'(busy), 0);
    check(tready === 1'b0, "midrst_tready", int'(tready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check(tready === 1'b1, "midrst_release_tready", int'(tready), 1);
    repeat (200) @(negedge clk);
    check(exp_q.size() == 0, "midrst_queue_empty", exp_q.size(), 0);

    // Randomized frames with random gaps and back-to-back runs
    b2b_flag = 1'b0;
    for (int i = 0; i < 25; i++) begin
      send(8'($urandom), 16'($urandom_range(0, 3)), 2'($urandom), 1'($urandom), b2b_flag);
      b2b_next = 1'($urandom);
      if (!b2b_next) begin
        wait_ready();
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      b2b_flag = b2b_next;
    end
    wait_ready();
    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
    check(!in_frame, "final_idle", int'(in_frame), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
